// File: rtl/next_frame_controller_if.sv
// Pixel-request handshake and SRAM port bundle for next_frame_controller.
`default_nettype none

interface next_frame_controller_if;
  logic        EN;
  logic        even_frame;
  logic        frame_clk;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [3:0]  pix_color;
  logic        pix_ready;
  logic        step_done;
  logic [15:0] pix_count;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic [19:0] SRAM_ADDRESS;

  // Controller side
  modport slave (
    input  EN, even_frame, frame_clk, pix_valid, pix_x, pix_y, pix_color,
    input  Data_from_SRAM,
    output pix_ready, step_done, pix_count,
    output Data_to_SRAM, SRAM_WE_N, SRAM_OE_N, SRAM_ADDRESS
  );

  // Accelerator / SRAM side
  modport master (
    output EN, even_frame, frame_clk, pix_valid, pix_x, pix_y, pix_color,
    output Data_from_SRAM,
    input  pix_ready, step_done, pix_count,
    input  Data_to_SRAM, SRAM_WE_N, SRAM_OE_N, SRAM_ADDRESS
  );
endinterface

`default_nettype wire

// File: rtl/next_frame_controller.sv
// Read-modify-write pixel plotter into the back half of a 4-bit-per-pixel
// frame buffer held in 16-bit SRAM words.
`default_nettype none

module next_frame_controller (
  input  logic                          Clk,
  input  logic                          Reset,
  next_frame_controller_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_SYNC = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    WR_SYNC = 3'd4,
    WR      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  color_q, color_d;
  logic        fsel_q, fsel_d;
  logic [15:0] merge_q, merge_d;
  logic        step_done_q, step_done_d;
  logic [15:0] pix_count_q, pix_count_d;

  logic        pix_ready;
  logic        accept;
  logic        drop;
  logic        wr_exit;
  logic [19:0] latched_addr;
  logic [3:0]  nib_shift;
  logic [15:0] nib_mask;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;

  assign pix_ready    = bus.EN & (state_q == IDLE);
  assign accept       = bus.pix_valid & pix_ready;
  assign drop         = (bus.pix_color == 4'd0) | (bus.pix_x >= 10'd640) |
                        (bus.pix_y >= 10'd480);
  assign wr_exit      = bus.EN & (state_q == WR);
  assign latched_addr = {1'b0, ~fsel_q, y_q, x_q[9:2]};
  assign nib_shift    = {x_q[1:0], 2'b00};
  assign nib_mask     = 16'hF << nib_shift;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    fsel_d      = fsel_q;
    merge_d     = merge_q;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_addr   = 20'd0;
    sram_wdata  = 16'd0;

    // With EN low everything holds and the SRAM port sits idle.
    if (bus.EN) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_d     = bus.pix_x;
            y_d     = bus.pix_y;
            color_d = bus.pix_color;
            fsel_d  = bus.even_frame;
            if (!drop) state_d = RD_SYNC;
          end
        end
        RD_SYNC: begin
          sram_oe_n = 1'b0;
          sram_addr = latched_addr;
          state_d   = RD;
        end
        RD: begin
          sram_oe_n = 1'b0;
          sram_addr = latched_addr;
          state_d   = RD_WAIT;
        end
        RD_WAIT: begin
          merge_d = (bus.Data_from_SRAM & ~nib_mask) |
                    ({12'd0, color_q} << nib_shift);
          state_d = WR_SYNC;
        end
        WR_SYNC: begin
          sram_we_n  = 1'b0;
          sram_addr  = latched_addr;
          sram_wdata = merge_q;
          state_d    = WR;
        end
        WR: begin
          sram_we_n  = 1'b0;
          sram_addr  = latched_addr;
          sram_wdata = merge_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign step_done_d = bus.EN & (state_d == IDLE);

  // A frame boundary restarts the count, but a write finishing on that same
  // cycle is the first pixel of the new frame.
  always_comb begin
    pix_count_d = pix_count_q;
    if (bus.frame_clk) begin
      pix_count_d = wr_exit ? 16'd1 : 16'd0;
    end else if (wr_exit && (pix_count_q != 16'hFFFF)) begin
      pix_count_d = pix_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      color_q     <= 4'd0;
      fsel_q      <= 1'b0;
      merge_q     <= 16'd0;
      step_done_q <= 1'b0;
      pix_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      fsel_q      <= fsel_d;
      merge_q     <= merge_d;
      step_done_q <= step_done_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign bus.pix_ready    = pix_ready;
  assign bus.step_done    = step_done_q;
  assign bus.pix_count    = pix_count_q;
  assign bus.SRAM_WE_N    = sram_we_n;
  assign bus.SRAM_OE_N    = sram_oe_n;
  assign bus.SRAM_ADDRESS = sram_addr;
  assign bus.Data_to_SRAM = sram_wdata;

endmodule

`default_nettype wire
